// File: rtl/fp_addsub_responder_if.sv
// fp_addsub_responder_if: request/response bundle between an add/sub
// initiator (master) and fp_addsub_responder (slave). Signal names are
// written from the responder's point of view (i_* into it, o_* out of it).
interface fp_addsub_responder_if #(
  parameter int BITS     = 381,
  parameter int CTL_BITS = 16
);

  // Request channel
  logic [BITS-1:0]     i_dat_a;
  logic [BITS-1:0]     i_dat_b;
  logic                i_sub;
  logic [CTL_BITS-1:0] i_ctl;
  logic                i_val;
  logic                o_rdy;

  // Result channel
  logic [BITS-1:0]     o_dat;
  logic [CTL_BITS-1:0] o_ctl;
  logic                o_err;
  logic                o_val;
  logic                i_rdy;

  modport master (
    output i_dat_a, i_dat_b, i_sub, i_ctl, i_val, i_rdy,
    input  o_rdy, o_dat, o_ctl, o_err, o_val
  );

  modport slave (
    input  i_dat_a, i_dat_b, i_sub, i_ctl, i_val, i_rdy,
    output o_rdy, o_dat, o_ctl, o_err, o_val
  );

endinterface

// File: rtl/fp_addsub_responder.sv
// fp_addsub_responder: in-order modular add/sub responder.
//   Stage 1 registers the raw a+b (or a-b with borrow), the tag, the op and
//   an out-of-range flag; stage 2 folds the raw value back into [0, P).
//   Results come back one per accepted request, in order, tag echoed.
// Build option: define FP_ADDSUB_OUT_SKID_EN to add a 2-entry output skid
//   buffer behind stage 2. o_rdy then comes straight from a flop and the
//   accept-to-result latency grows from 2 to 3 cycles; throughput stays
//   one result per cycle.
module fp_addsub_responder #(
  parameter int              BITS     = 381,
  parameter logic [BITS-1:0] P        = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
  parameter int              CTL_BITS = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  fp_addsub_responder_if.slave bus
);

  localparam logic [BITS:0] P_EXT = {1'b0, P};

  // Stage 1: raw sum / difference (MSB is carry for add, borrow for sub)
  logic                s1_v;
  logic [BITS:0]       s1_sum;
  logic                s1_sub;
  logic                s1_err;
  logic [CTL_BITS-1:0] s1_ctl;

  // Stage 2: corrected result
  logic                s2_v;
  logic [BITS-1:0]     s2_dat;
  logic [CTL_BITS-1:0] s2_ctl;
  logic                s2_err;

  // Handshake / advance controls
  logic                accept;   // request taken this cycle
  logic                adv1;     // stage 1 may load this cycle
  logic                adv2;     // stage 2 may load this cycle

  logic [BITS:0]       a_ext;
  logic [BITS:0]       b_ext;
  logic [BITS:0]       s1_sum_d;
  logic                s1_err_d;
  logic [BITS-1:0]     s2_dat_d;

  assign a_ext    = {1'b0, bus.i_dat_a};
  assign b_ext    = {1'b0, bus.i_dat_b};
  assign s1_sum_d = bus.i_sub ? (a_ext - b_ext) : (a_ext + b_ext);
  assign s1_err_d = (bus.i_dat_a >= P) || (bus.i_dat_b >= P);

  assign accept = bus.i_val && bus.o_rdy;
  // An empty stage 1 can always fill, which collapses bubbles behind a stall.
  assign adv1   = !s1_v || adv2;

  // Fold the stage-1 raw value back into the field: subtract P from an
  // oversized sum, add P back after a borrow; keep the low BITS bits.
  always_comb begin
    // NOTE: give every combinational output a default before any branch so
    // no path leaves it unassigned; a missing default infers a latch.
    s2_dat_d = s1_sum[BITS-1:0];
    if (s1_sub) begin
      if (s1_sum[BITS]) begin
        s2_dat_d = s1_sum[BITS-1:0] + P;
      end
    end else if (s1_sum >= P_EXT) begin
      s2_dat_d = s1_sum[BITS-1:0] - P;
    end
  end

  // Two-stage pipeline; each stage loads only when its successor can take
  // what it holds, so a stalled result never changes under the consumer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
      s1_sub <= 1'b0;
      s1_err <= 1'b0;
      s1_ctl <= '0;
      s2_v   <= 1'b0;
      s2_dat <= '0;
      s2_ctl <= '0;
      s2_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge
      // values, so stage 2 reads the old stage 1 no matter the statement order.
      if (adv1) begin
        s1_v <= accept;
        if (accept) begin
          s1_sum <= s1_sum_d;
          s1_sub <= bus.i_sub;
          s1_err <= s1_err_d;
          s1_ctl <= bus.i_ctl;
        end
      end
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_dat <= s2_dat_d;
          s2_ctl <= s1_ctl;
          s2_err <= s1_err;
        end
      end
    end
  end

`ifdef FP_ADDSUB_OUT_SKID_EN

  typedef struct packed {
    logic [BITS-1:0]     dat;
    logic [CTL_BITS-1:0] ctl;
    logic                err;
  } res_t;

  res_t       skid_mem [2];
  logic       skid_wr;         // slot the next result is written to
  logic       skid_rd;         // slot currently presented on o_*
  logic [1:0] skid_cnt;        // results held in the skid buffer
  logic [2:0] inflight;        // requests accepted but not yet consumed
  logic [2:0] inflight_nxt;
  logic       rdy_q;
  logic       push;
  logic       pop;

  assign pop  = (skid_cnt != 2'd0) && bus.i_rdy;
  // A full skid buffer frees a slot only when the consumer takes its head.
  assign adv2 = !s2_v || (skid_cnt != 2'd2) || bus.i_rdy;
  assign push = s2_v && adv2;

  // Outstanding-request count after this edge. With s1, s2 and two skid
  // slots the design holds four results; below that a hole exists and the
  // bubble-collapsing chain lets stage 1 take a new request next cycle.
  always_comb begin
    inflight_nxt = inflight;
    case ({accept, pop})
      2'b10:   inflight_nxt = inflight + 3'd1;
      2'b01:   inflight_nxt = inflight - 3'd1;
      default: inflight_nxt = inflight;
    endcase
  end

  // Skid buffer storage, pointers and the registered request-ready.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      // NOTE: the two skid slots are reset (unlike a real RAM) because o_dat,
      // o_ctl and o_err are read straight from them and must be 0 in reset.
      for (int i = 0; i < 2; i++) begin
        skid_mem[i] <= '0;
      end
      skid_wr  <= 1'b0;
      skid_rd  <= 1'b0;
      skid_cnt <= 2'd0;
      inflight <= 3'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) begin
        skid_mem[skid_wr] <= '{dat: s2_dat, ctl: s2_ctl, err: s2_err};
        skid_wr           <= ~skid_wr;
      end
      if (pop) begin
        skid_rd <= ~skid_rd;
      end
      case ({push, pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
      inflight <= inflight_nxt;
      rdy_q    <= (inflight_nxt != 3'd4);
    end
  end

  assign bus.o_rdy = rdy_q;
  assign bus.o_val = (skid_cnt != 2'd0);
  assign bus.o_dat = skid_mem[skid_rd].dat;
  assign bus.o_ctl = skid_mem[skid_rd].ctl;
  assign bus.o_err = skid_mem[skid_rd].err;

`else

  logic rdy_en;   // holds o_rdy low until the first edge after reset release

  assign adv2 = !s2_v || bus.i_rdy;

  // Request-ready enable: rises on the first clock edge out of reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  assign bus.o_rdy = rdy_en && adv1;
  assign bus.o_val = s2_v;
  assign bus.o_dat = s2_dat;
  assign bus.o_ctl = s2_ctl;
  assign bus.o_err = s2_err;

`endif

endmodule

// File: tb/tb_fp_addsub_responder.sv
// tb_fp_addsub_responder: directed bench for fp_addsub_responder at
// BITS=8, P=251. Expected results are hand-computed and queued in order;
// a negedge monitor compares every presented result with the queue head,
// so ordering, duplicates and stability under stall are all covered.
module tb_fp_addsub_responder;

  localparam int         BITS     = 8;
  localparam int         CTL_BITS = 16;
  localparam logic [7:0] P        = 8'd251;
`ifdef FP_ADDSUB_OUT_SKID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0]  dat;
    logic [15:0] ctl;
    logic        err;
    int          acc;   // cycle in which the request was accepted
    bit          lat;   // check exact latency for this result
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  bit          mon_en = 1'b1;
  logic [31:0] stall_pat = 32'd0;
  int          stall_left = 0;

  fp_addsub_responder_if #(.BITS(BITS), .CTL_BITS(CTL_BITS)) bus ();

  fp_addsub_responder #(.BITS(BITS), .P(P), .CTL_BITS(CTL_BITS)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result-side ready: follows stall_pat (LSB first) while stall_left > 0.
  initial begin
    bus.i_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        bus.i_rdy  = stall_pat[0];
        stall_pat  = stall_pat >> 1;
        stall_left = stall_left - 1;
      end else begin
        bus.i_rdy = 1'b1;
      end
    end
  end

  // Output monitor: every presented result must match the oldest expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && bus.o_val) begin
        if (exp_q.size() == 0) begin
          check("extra_result", 32'(bus.o_val), 32'd0);
        end else begin
          e = exp_q[0];
          check($sformatf("dat[ctl=%0h]", e.ctl), 32'(bus.o_dat), 32'(e.dat));
          check($sformatf("ctl[ctl=%0h]", e.ctl), 32'(bus.o_ctl), 32'(e.ctl));
          check($sformatf("err[ctl=%0h]", e.ctl), 32'(bus.o_err), 32'(e.err));
          if (bus.i_rdy) begin
            if (e.lat) begin
              check($sformatf("latency[ctl=%0h]", e.ctl), 32'(cyc - e.acc), 32'(LAT));
            end
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, queue its result.
  // Called at posedge+1; returns at posedge+1 so calls can run back to back.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [15:0] ctl, input logic [7:0] exp_dat,
                      input logic exp_err, input bit keep, input bit lat,
                      output int acc);
    bit   got;
    int   waited;
    exp_t e;
    bus.i_dat_a = a;
    bus.i_dat_b = b;
    bus.i_sub   = sub;
    bus.i_ctl   = ctl;
    bus.i_val   = 1'b1;
    got    = 1'b0;
    waited = 0;
    acc    = 0;
    while (!got && waited < 64) begin
      @(negedge clk);
      got = bus.o_rdy;
      acc = cyc;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.i_val = 1'b0;
    check($sformatf("accept[ctl=%0h]", ctl), 32'(got), 32'd1);
    if (got && keep) begin
      e.dat = exp_dat;
      e.ctl = ctl;
      e.err = exp_err;
      e.acc = acc;
      e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int prev;
    rst_n       = 1'b0;
    bus.i_dat_a = 8'd0;
    bus.i_dat_b = 8'd0;
    bus.i_sub   = 1'b0;
    bus.i_ctl   = 16'd0;
    bus.i_val   = 1'b1;   // request pending during reset must not be taken
    prev        = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_o_val", 32'(bus.o_val), 32'd0);
    check("rst_o_rdy", 32'(bus.o_rdy), 32'd0);
    check("rst_o_err", 32'(bus.o_err), 32'd0);
    check("rst_o_dat", 32'(bus.o_dat), 32'd0);
    check("rst_o_ctl", 32'(bus.o_ctl), 32'd0);
    bus.i_val = 1'b0;
    #2 rst_n = 1'b1;
    #1 check("rdy_before_first_edge", 32'(bus.o_rdy), 32'd0);
    @(posedge clk);
    #1 check("rdy_after_first_edge", 32'(bus.o_rdy), 32'd1);

    // Single add / sub with latency
    send(8'd250, 8'd3, 1'b0, 16'h0011, 8'd2, 1'b0, 1'b1, 1'b1, acc);
    drain();
    send(8'd3,   8'd250, 1'b1, 16'h0022, 8'd4, 1'b0, 1'b1, 1'b1, acc);
    send(8'd9,   8'd9,   1'b1, 16'h0023, 8'd0, 1'b0, 1'b1, 1'b1, acc);
    // Boundaries: sum exactly P, sum past 2^BITS, zero, borrow wrap
    send(8'd250, 8'd1,   1'b0, 16'h0024, 8'd0,   1'b0, 1'b1, 1'b1, acc);
    send(8'd250, 8'd250, 1'b0, 16'h0025, 8'd249, 1'b0, 1'b1, 1'b1, acc);
    send(8'd0,   8'd0,   1'b1, 16'h0026, 8'd0,   1'b0, 1'b1, 1'b1, acc);
    send(8'd0,   8'd250, 1'b1, 16'h0027, 8'd1,   1'b0, 1'b1, 1'b1, acc);
    drain();

    // Ten back-to-back adds, one accepted per cycle
    for (int k = 0; k < 10; k++) begin
      send(8'(k), 8'(k), 1'b0, 16'(16'h0100 + k), 8'(2 * k), 1'b0, 1'b1, 1'b1, acc);
      if (k > 0) check($sformatf("b2b_accept[%0d]", k), 32'(acc - prev), 32'd1);
      prev = acc;
    end
    drain();

    // Same stream with i_rdy = 1,0,1,0,... then five cycles of 0
    @(negedge clk);
    stall_pat  = 32'h0000_0155;
    stall_left = 15;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      send(8'(k), 8'(k), 1'b0, 16'(16'h0200 + k), 8'(2 * k), 1'b0, 1'b1, 1'b0, acc);
    end
    drain();

    // Out-of-range operands flag only their own result
    send(8'd252, 8'd1,   1'b0, 16'h0036, 8'd2,   1'b1, 1'b1, 1'b1, acc);
    send(8'd1,   8'd2,   1'b0, 16'h0037, 8'd3,   1'b0, 1'b1, 1'b1, acc);
    send(8'd255, 8'd1,   1'b1, 16'h0038, 8'd254, 1'b1, 1'b1, 1'b1, acc);
    send(8'd1,   8'd251, 1'b0, 16'h0039, 8'd1,   1'b1, 1'b1, 1'b1, acc);
    drain();

    // Reset with two requests in flight; neither may come out afterwards
    @(negedge clk);
    mon_en     = 1'b0;
    stall_pat  = 32'd0;
    stall_left = 12;
    @(posedge clk);
    #1;
    send(8'd5, 8'd6, 1'b0, 16'h0050, 8'd11, 1'b0, 1'b0, 1'b0, acc);
    send(8'd7, 8'd8, 1'b0, 16'h0051, 8'd15, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_o_val", 32'(bus.o_val), 32'd0);
    check("midrst_o_rdy", 32'(bus.o_rdy), 32'd0);
    check("midrst_o_dat", 32'(bus.o_dat), 32'd0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("stale_o_val[%0d]", k), 32'(bus.o_val), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'd1, 8'd1, 1'b0, 16'h0060, 8'd2, 1'b0, 1'b1, 1'b1, acc);
    drain();

    check("leftover_results", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_responder.md
FP_ADDSUB_RESPONDER -- requirements
Module: fp_addsub_responder

Interface
REQ-001 Parameter BITS, default 381, operand and result width in bits.
REQ-002 Parameter P, default the BLS12-381 base field prime, modulus (P < 2^BITS).
REQ-003 Parameter CTL_BITS, default 16, request tag width, echoed unchanged with the result.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 i_dat_a  in  BITS  operand a.
REQ-007 i_dat_b  in  BITS  operand b.
REQ-008 i_sub  in  1  0 = (a+b) mod P, 1 = (a-b) mod P.
REQ-009 i_ctl  in  CTL_BITS  request tag.
REQ-010 i_val  in  1  request valid.
REQ-011 o_rdy  out  1  request accepted when i_val && o_rdy.
REQ-012 o_dat  out  BITS  result.
REQ-013 o_ctl  out  CTL_BITS  tag of the request that produced o_dat.
REQ-014 o_err  out  1  asserted with a result whose a or b was >= P.
REQ-015 o_val  out  1  result valid.
REQ-016 i_rdy  in  1  result consumed when o_val && i_rdy.

Function
REQ-017 Block SHALL act as the responder for an initiator's add/sub request stream: one result per accepted request, strictly in order, tag echoed.
REQ-018 Stage 1 SHALL register s = a+b (BITS+1 bits) or d = a-b with borrow, plus tag, op and error flag.
REQ-019 Stage 2 SHALL correct: add -> s-P if s >= P else s; sub -> d+P if borrow else d; result truncated to BITS.
REQ-020 Latency SHALL be exactly 2 cycles from accept to o_val when i_rdy is held 1.
REQ-021 Throughput SHALL be one request per cycle with i_rdy held 1.
REQ-022 Pipeline SHALL advance only when stage 2 is empty or i_rdy=1; otherwise all stages hold and data/tag SHALL not change.
REQ-023 Without skid buffer, o_rdy SHALL equal (!stage2 valid || i_rdy) || !stage1 valid (bubble collapse allowed).
REQ-024 o_dat, o_ctl, o_err SHALL be stable while o_val=1 and i_rdy=0.
REQ-025 Operand >= P SHALL still produce the corrected-formula result, with o_err=1 for that result only.
REQ-026 Simultaneous accept and output consume in the same cycle SHALL lose no data and duplicate no result.

Reset
REQ-027 While i_rst=0: o_val=0, o_rdy=0, o_err=0, o_dat=0, o_ctl=0, all stage valids cleared.
REQ-028 Reset mid-operation SHALL discard all in-flight requests; no result emitted for them after release.
REQ-029 o_rdy SHALL rise no earlier than the first clock edge after i_rst goes 1.

Configuration
REQ-030 Macro FP_ADDSUB_OUT_SKID_EN defined: 2-entry output skid buffer added after stage 2; o_rdy SHALL be a register output (no combinational path from i_rdy), latency becomes 3 cycles, throughput still 1/cycle.
REQ-031 Macro undefined: no skid buffer, behaviour per REQ-020 and REQ-023.

Verification (BITS=8, P=251)
REQ-032 add a=250, b=3, ctl=0x0011 -> o_dat=2, o_ctl=0x0011, o_err=0, 2 cycles after accept (3 with macro).
REQ-033 sub a=3, b=250, ctl=0x0022 -> o_dat=4, o_err=0; sub a=9, b=9 -> o_dat=0.
REQ-034 10 back-to-back adds a=k, b=k (k=0..9) with i_rdy=1 -> results 0,2,...,18 on consecutive cycles, tags in order.
REQ-035 Same stream with i_rdy toggled 1010... and held 0 for 5 cycles -> all 10 results delivered once, in order, outputs stable while stalled.
REQ-036 add a=252, b=1 -> o_dat=2, o_err=1; following valid request -> o_err=0.
REQ-037 Assert i_rst=0 with 2 requests in flight -> o_val=0 immediately, no stale result after release; next request a=1, b=1 add -> o_dat=2.
